// File: rtl/layer_loader_pkg.sv
// Shared definitions for the layer parameter loader: data word width and FSM states.
// The layer sequencer imports this to reuse the state encoding.
package layer_loader_pkg;

   localparam int N = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/layer_loader.sv
// Fetches sx+2 parameter words per node from a word-addressed source and shifts
// them, node by node, into one layer's parameter shift registers over a shared bus.
module layer_loader
   import layer_loader_pkg::*;
#(
   parameter int sx = 4,
   parameter int sl = 4,
   parameter int aw = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [aw-1:0] base_addr,
   output logic          busy,
   output logic          done,
   output logic          src_req,
   output logic [aw-1:0] src_addr,
   input  logic          src_valid,
   input  logic [N-1:0]  src_data,
   output logic [N-1:0]  bus_o,
   output logic          bus_oe,
   output logic [sl-1:0] we
);

   localparam int WPN = sx + 2;
   localparam int WCW = $clog2(WPN);
   localparam int NKW = (sl > 1) ? $clog2(sl) : 1;
   localparam logic [WCW-1:0] WC_LAST = WCW'(WPN - 1);
   localparam logic [NKW-1:0] NK_LAST = NKW'(sl - 1);

   state_t          state_reg, state_next;
   logic [aw-1:0]   addr_reg, addr_next;
   logic [WCW-1:0]  wc_reg, wc_next;
   logic [NKW-1:0]  nk_reg, nk_next;
   logic [N-1:0]    word_reg, word_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         wc_reg    <= '0;
         nk_reg    <= '0;
         word_reg  <= '0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         wc_reg    <= wc_next;
         nk_reg    <= nk_next;
         word_reg  <= word_next;
      end
   end

   // Outputs decode from registered state only, so src_valid never reaches we/bus_oe directly.
   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      wc_next    = wc_reg;
      nk_next    = nk_reg;
      word_next  = word_reg;
      busy       = 1'b0;
      done       = 1'b0;
      src_req    = 1'b0;
      src_addr   = addr_reg;
      bus_o      = '0;
      bus_oe     = 1'b0;
      we         = '0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               addr_next  = base_addr;
               wc_next    = '0;
               nk_next    = '0;
               state_next = FETCH;
            end
         end
         FETCH: begin
            busy    = 1'b1;
            src_req = 1'b1;
            if (src_valid) begin
               word_next  = src_data;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy   = 1'b1;
            bus_oe = 1'b1;
            bus_o  = word_reg;
            // Node 0 owns the MSB of the enable vector.
            we[sl-1-int'(nk_reg)] = 1'b1;
            addr_next = addr_reg + aw'(1);
            if (wc_reg != WC_LAST) begin
               wc_next    = wc_reg + WCW'(1);
               state_next = FETCH;
            end else begin
               wc_next = '0;
               if (nk_reg != NK_LAST) begin
                  nk_next    = nk_reg + NKW'(1);
                  state_next = FETCH;
               end else begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_layer_loader.sv
// Randomized self-checking bench for layer_loader (sx=2, sl=3): address/data/enable
// sequence, done latency, ignored restarts, async reset, address wrap, spurious valids.
module tb_layer_loader;
   import layer_loader_pkg::*;

   localparam int SX    = 2;
   localparam int SL    = 3;
   localparam int AW    = 16;
   localparam int WPN   = SX + 2;
   localparam int TOTAL = SL * WPN;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic          busy, done, src_req, bus_oe;
   logic [AW-1:0] src_addr;
   logic          src_valid = 1'b0;
   logic [N-1:0]  src_data = '0;
   logic [N-1:0]  bus_o;
   logic [SL-1:0] we;

   int vectors = 0;
   int miscompares = 0;

   int       src_delay = 0;
   bit       spurious = 1'b0;
   int       wait_cnt = 0;
   logic [N-1:0] salt = '0;

   layer_loader #(.sx(SX), .sl(SL), .aw(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .busy(busy), .done(done), .src_req(src_req), .src_addr(src_addr),
      .src_valid(src_valid), .src_data(src_data),
      .bus_o(bus_o), .bus_oe(bus_oe), .we(we)
   );

   always #5 clk = ~clk;

   // Parameter memory contents: a scrambled function of the address.
   function automatic logic [N-1:0] word_at(input logic [AW-1:0] a);
      logic [31:0] p;
      p = 32'(a) * 32'd40503;
      return p[N-1:0] ^ salt;
   endfunction

   // Source model: answers after src_delay wait cycles; optional garbage valids when idle.
   always @(negedge clk) begin
      if (src_req) begin
         src_valid = (wait_cnt >= src_delay);
         src_data  = src_valid ? word_at(src_addr) : N'($urandom);
         wait_cnt  = wait_cnt + 1;
      end else begin
         wait_cnt  = 0;
         src_valid = spurious && ($urandom_range(0, 1) == 1);
         src_data  = N'($urandom);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_src_req"}, 32'(src_req), 32'd0);
      check({tag, "_bus_oe"}, 32'(bus_oe), 32'd0);
      check({tag, "_we"}, 32'(we), 32'd0);
      check({tag, "_bus_o"}, 32'(bus_o), 32'd0);
   endtask

   // One full load; abort_at >= 0 pulls reset once that many words have been shifted.
   task automatic run_load(input logic [AW-1:0] base, input int delay, input bit repulse,
                           input bit spur, input int abort_at);
      int            edges, nshift, exp_cycles, node;
      bit            seen_done;
      logic [AW-1:0] exp_addr;
      logic [SL-1:0] exp_we;
      src_delay = delay;
      spurious  = spur;
      @(negedge clk);
      start = 1'b1;
      base_addr = base;
      @(negedge clk);
      start = 1'b0;
      base_addr = AW'($urandom);
      edges = 0;
      nshift = 0;
      seen_done = 1'b0;
      exp_cycles = TOTAL * (2 + delay) + 1;
      $display("load base=%04h delay=%0d repulse=%0d spurious=%0d abort_at=%0d",
               base, delay, repulse, spur, abort_at);
      while (!seen_done && edges < 2000) begin
         start = repulse && (edges == 2 || edges == 9);
         exp_addr = base + AW'(nshift);
         if (done) begin
            check("done_latency", 32'(edges + 1), 32'(exp_cycles));
            check("done_words", 32'(nshift), 32'(TOTAL));
            check("done_busy", 32'(busy), 32'd0);
            seen_done = 1'b1;
         end else begin
            check("busy", 32'(busy), 32'd1);
            if (bus_oe) begin
               node   = nshift / WPN;
               exp_we = SL'(1) << (SL - 1 - node);
               check("bus_o", 32'(bus_o), 32'(word_at(exp_addr)));
               check("we", 32'(we), 32'(exp_we));
               check("req_in_shift", 32'(src_req), 32'd0);
               nshift++;
            end else begin
               check("we_idle", 32'(we), 32'd0);
               if (src_req) check("src_addr", 32'(src_addr), 32'(exp_addr));
            end
            if (abort_at >= 0 && nshift == abort_at) begin
               #1 rst = 1'b0;
               #1 check_quiet("async_rst");
               check("rst_src_addr", 32'(src_addr), 32'd0);
               @(negedge clk);
               rst = 1'b1;
               start = 1'b0;
               return;
            end
         end
         @(negedge clk);
         edges++;
      end
      start = 1'b0;
      if (!seen_done) check("done_timeout", 32'd0, 32'd1);
      check_quiet("after_done");
   endtask

   initial begin
      salt = N'($urandom);
      repeat (3) @(negedge clk);
      check_quiet("reset");
      check("reset_src_addr", 32'(src_addr), 32'd0);
      rst = 1'b1;

      run_load(16'h0010, 0, 1'b0, 1'b0, -1);
      run_load(16'h0010, 3, 1'b0, 1'b0, -1);
      run_load(AW'($urandom), 0, 1'b1, 1'b0, -1);
      run_load(16'h0010, 0, 1'b0, 1'b0, 6);
      run_load(16'h0010, 0, 1'b0, 1'b0, -1);
      run_load(16'hFFFE, 0, 1'b0, 1'b0, -1);
      run_load(AW'($urandom), $urandom_range(0, 2), 1'b0, 1'b1, -1);
      run_load(AW'($urandom), 1, 1'b1, 1'b1, -1);

      // Idle with garbage valids: nothing may move.
      spurious = 1'b1;
      repeat (8) begin
         @(negedge clk);
         check_quiet("idle_spurious");
      end
      spurious = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
